// File: rtl/alu_arbiter.sv
`default_nettype none
// =====================================================================
// alu_arbiter : round-robin sharing of one combinational ALU between
//               two valid/ready requesters, one transaction in flight.
// Revision    : 1.0  initial release
// =====================================================================
module alu_arbiter #(
   parameter int WIDTH       = 16,
   parameter int OP_WIDTH    = 4,
   parameter int HOLD_CYCLES = 1
) (
   input  logic                clock_i,
   input  logic                reset_i,
   input  logic                req0_valid_i,
   input  logic                req1_valid_i,
   output logic                req0_ready_o,
   output logic                req1_ready_o,
   input  logic [OP_WIDTH-1:0] req0_op_i,
   input  logic [OP_WIDTH-1:0] req1_op_i,
   input  logic [WIDTH-1:0]    req0_a_i,
   input  logic [WIDTH-1:0]    req1_a_i,
   input  logic [WIDTH-1:0]    req0_b_i,
   input  logic [WIDTH-1:0]    req1_b_i,
   input  logic [2:0]          req0_ltgt_i,
   input  logic [2:0]          req1_ltgt_i,
   input  logic                req0_eq_i,
   input  logic                req1_eq_i,
   output logic                rsp0_valid_o,
   output logic                rsp1_valid_o,
   input  logic                rsp0_ready_i,
   input  logic                rsp1_ready_i,
   output logic [WIDTH-1:0]    rsp_data_o,
   output logic                rsp_flag_o,
   output logic [OP_WIDTH-1:0] alu_op_o,
   output logic [WIDTH-1:0]    alu_res_o,
   output logic [WIDTH-1:0]    alu_register_o,
   output logic [2:0]          alu_ltgt_o,
   output logic                alu_eq_o,
   input  logic [WIDTH-1:0]    alu_out_i,
   input  logic                alu_compres_i,
   output logic                busy_o,
   output logic                grant_id_o
);

   localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CNT_W-1:0] c_hold_load = CNT_W'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic                 last_grant_q, last_grant_d;
   logic                 grant_id_q, grant_id_d;
   logic [OP_WIDTH-1:0]  op_q, op_d;
   logic [WIDTH-1:0]     a_q, a_d;
   logic [WIDTH-1:0]     b_q, b_d;
   logic [2:0]           ltgt_q, ltgt_d;
   logic                 eq_q, eq_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]     rsp_data_q, rsp_data_d;
   logic                 rsp_flag_q, rsp_flag_d;

   logic w_win0, w_win1, w_idle, w_exec, w_resp, w_rsp_hs;

   // req1 wins when alone or when req0 was served last on a tie
   assign w_win1 = req1_valid_i & (~req0_valid_i | ~last_grant_q);
   assign w_win0 = req0_valid_i & ~w_win1;

   assign w_idle   = (state_q == IDLE);
   assign w_exec   = (state_q == EXEC);
   assign w_resp   = (state_q == RESP);
   assign w_rsp_hs = grant_id_q ? rsp1_ready_i : rsp0_ready_i;

   assign req0_ready_o   = w_idle & ~reset_i & w_win0;
   assign req1_ready_o   = w_idle & ~reset_i & w_win1;
   assign rsp0_valid_o   = w_resp & ~grant_id_q;
   assign rsp1_valid_o   = w_resp & grant_id_q;
   assign rsp_data_o     = rsp_data_q;
   assign rsp_flag_o     = rsp_flag_q;
   assign alu_op_o       = w_exec ? op_q   : '0;
   assign alu_res_o      = w_exec ? a_q    : '0;
   assign alu_register_o = w_exec ? b_q    : '0;
   assign alu_ltgt_o     = w_exec ? ltgt_q : '0;
   assign alu_eq_o       = w_exec & eq_q;
   assign busy_o         = ~w_idle;
   assign grant_id_o     = grant_id_q;

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         grant_id_q   <= 1'b0;
         op_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         ltgt_q       <= '0;
         eq_q         <= 1'b0;
         cnt_q        <= '0;
         rsp_data_q   <= '0;
         rsp_flag_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_id_q   <= grant_id_d;
         op_q         <= op_d;
         a_q          <= a_d;
         b_q          <= b_d;
         ltgt_q       <= ltgt_d;
         eq_q         <= eq_d;
         cnt_q        <= cnt_d;
         rsp_data_q   <= rsp_data_d;
         rsp_flag_q   <= rsp_flag_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_id_d   = grant_id_q;
      op_d         = op_q;
      a_d          = a_q;
      b_d          = b_q;
      ltgt_d       = ltgt_q;
      eq_d         = eq_q;
      cnt_d        = cnt_q;
      rsp_data_d   = rsp_data_q;
      rsp_flag_d   = rsp_flag_q;
      case (state_q)
         IDLE: begin
            if (w_win0 | w_win1) begin
               state_d      = EXEC;
               last_grant_d = w_win1;
               grant_id_d   = w_win1;
               op_d         = w_win1 ? req1_op_i   : req0_op_i;
               a_d          = w_win1 ? req1_a_i    : req0_a_i;
               b_d          = w_win1 ? req1_b_i    : req0_b_i;
               ltgt_d       = w_win1 ? req1_ltgt_i : req0_ltgt_i;
               eq_d         = w_win1 ? req1_eq_i   : req0_eq_i;
               cnt_d        = c_hold_load;
            end
         end
         EXEC: begin
            // operands stay on the ALU until the hold count expires
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               rsp_data_d = alu_out_i;
               rsp_flag_d = alu_compres_i;
               state_d    = RESP;
            end
         end
         RESP: begin
            if (w_rsp_hs) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// tb_alu_arbiter : scoreboard bench driving two alu_arbiter instances
// (HOLD_CYCLES 1 and 3) with directed and random traffic.
module tb_alu_arbiter;

   typedef struct {
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [2:0]  ltgt;
      logic        eq;
   } stim_t;

   typedef struct {
      logic        id;
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [2:0]  ltgt;
      logic        eq;
      int          acc;
   } txn_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   logic        rq_valid [2][2];
   logic        rq_ready [2][2];
   logic [3:0]  rq_op    [2][2];
   logic [15:0] rq_a     [2][2];
   logic [15:0] rq_b     [2][2];
   logic [2:0]  rq_ltgt  [2][2];
   logic        rq_eq    [2][2];
   logic        rs_valid [2][2];
   logic        rs_ready [2][2];
   logic [15:0] rsp_data [2];
   logic        rsp_flag [2];
   logic [3:0]  alu_op   [2];
   logic [15:0] alu_res  [2];
   logic [15:0] alu_reg  [2];
   logic [2:0]  alu_ltgt [2];
   logic        alu_eq   [2];
   logic [15:0] alu_out  [2];
   logic        alu_cmp  [2];
   logic        busy     [2];
   logic        gid      [2];

   stim_t sq [4][$];
   int    gap [4];
   int    rs_mode [4];
   bit    infl [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] ref_alu(input logic [3:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         default: return ~a;
      endcase
   endfunction

   function automatic logic ref_cmp(input logic [2:0] ltgt, input logic eq,
                                    input logic [15:0] a, input logic [15:0] b);
      if (eq) return a == b;
      case (ltgt[1:0])
         2'd0:    return a < b;
         2'd1:    return a > b;
         2'd2:    return a <= b;
         default: return a >= b;
      endcase
   endfunction

   task automatic chk(input int inst, input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL i%0d %s: got %0h expected %0h (cycle %0d)", inst, name, act, exp, cyc);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_inst
      alu_arbiter #(.WIDTH(16), .OP_WIDTH(4), .HOLD_CYCLES(g == 0 ? 1 : 3)) u_dut (
         .clock_i        (clk),
         .reset_i        (rst),
         .req0_valid_i   (rq_valid[g][0]),
         .req1_valid_i   (rq_valid[g][1]),
         .req0_ready_o   (rq_ready[g][0]),
         .req1_ready_o   (rq_ready[g][1]),
         .req0_op_i      (rq_op[g][0]),
         .req1_op_i      (rq_op[g][1]),
         .req0_a_i       (rq_a[g][0]),
         .req1_a_i       (rq_a[g][1]),
         .req0_b_i       (rq_b[g][0]),
         .req1_b_i       (rq_b[g][1]),
         .req0_ltgt_i    (rq_ltgt[g][0]),
         .req1_ltgt_i    (rq_ltgt[g][1]),
         .req0_eq_i      (rq_eq[g][0]),
         .req1_eq_i      (rq_eq[g][1]),
         .rsp0_valid_o   (rs_valid[g][0]),
         .rsp1_valid_o   (rs_valid[g][1]),
         .rsp0_ready_i   (rs_ready[g][0]),
         .rsp1_ready_i   (rs_ready[g][1]),
         .rsp_data_o     (rsp_data[g]),
         .rsp_flag_o     (rsp_flag[g]),
         .alu_op_o       (alu_op[g]),
         .alu_res_o      (alu_res[g]),
         .alu_register_o (alu_reg[g]),
         .alu_ltgt_o     (alu_ltgt[g]),
         .alu_eq_o       (alu_eq[g]),
         .alu_out_i      (alu_out[g]),
         .alu_compres_i  (alu_cmp[g]),
         .busy_o         (busy[g]),
         .grant_id_o     (gid[g])
      );

      assign alu_out[g] = ref_alu(alu_op[g], alu_res[g], alu_reg[g]);
      assign alu_cmp[g] = ref_cmp(alu_ltgt[g], alu_eq[g], alu_res[g], alu_reg[g]);

      for (genvar n = 0; n < 2; n++) begin : g_req
         // requester: holds each operation until it is accepted
         initial begin : p_drv
            bit    acc;
            stim_t s;
            rq_valid[g][n] = 1'b0;
            rq_op[g][n]    = '0;
            rq_a[g][n]     = '0;
            rq_b[g][n]     = '0;
            rq_ltgt[g][n]  = '0;
            rq_eq[g][n]    = 1'b0;
            forever begin
               @(negedge clk);
               acc = rq_valid[g][n] && rq_ready[g][n] && !rst;
               @(posedge clk);
               #1;
               if (acc) rq_valid[g][n] = 1'b0;
               if (!rq_valid[g][n] && !rst && sq[g*2+n].size() != 0 &&
                   $urandom_range(0, 99) >= gap[g*2+n]) begin
                  s = sq[g*2+n].pop_front();
                  rq_valid[g][n] = 1'b1;
                  rq_op[g][n]    = s.op;
                  rq_a[g][n]     = s.a;
                  rq_b[g][n]     = s.b;
                  rq_ltgt[g][n]  = s.ltgt;
                  rq_eq[g][n]    = s.eq;
               end
            end
         end

         initial begin : p_rdy
            rs_ready[g][n] = 1'b1;
            forever begin
               @(posedge clk);
               #1;
               case (rs_mode[g*2+n])
                  0:       rs_ready[g][n] = 1'b1;
                  1:       rs_ready[g][n] = 1'b0;
                  default: rs_ready[g][n] = 1'($urandom_range(0, 1));
               endcase
            end
         end
      end

      // scoreboard: reference arbiter + in-flight transaction timeline
      txn_t q[$];
      bit   last_q  = 1'b1;
      logic exp_gid = 1'b0;

      always @(negedge clk) begin : p_mon
         txn_t t;
         bit   e0, e1, ex, inf;
         if (rst) begin
            q.delete();
            last_q  = 1'b1;
            exp_gid = 1'b0;
            infl[g] = 1'b0;
            chk(g, "ready0_in_reset", rq_ready[g][0], 0);
            chk(g, "ready1_in_reset", rq_ready[g][1], 0);
         end else begin
            inf = q.size() != 0;
            e0 = !inf && rq_valid[g][0] && (!rq_valid[g][1] || last_q);
            e1 = !inf && rq_valid[g][1] && (!rq_valid[g][0] || !last_q);
            chk(g, "req0_ready", rq_ready[g][0], e0);
            chk(g, "req1_ready", rq_ready[g][1], e1);
            chk(g, "busy", busy[g], inf);
            chk(g, "grant_id", gid[g], exp_gid);
            if (inf) begin
               t  = q[0];
               ex = cyc < t.acc + (g == 0 ? 1 : 3);
               chk(g, "alu_op",   alu_op[g],   ex ? t.op   : 4'd0);
               chk(g, "alu_res",  alu_res[g],  ex ? t.a    : 16'd0);
               chk(g, "alu_reg",  alu_reg[g],  ex ? t.b    : 16'd0);
               chk(g, "alu_ltgt", alu_ltgt[g], ex ? t.ltgt : 3'd0);
               chk(g, "alu_eq",   alu_eq[g],   ex ? t.eq   : 1'b0);
               chk(g, "rsp0_valid", rs_valid[g][0], !ex && !t.id);
               chk(g, "rsp1_valid", rs_valid[g][1], !ex && t.id);
               if (!ex) begin
                  chk(g, "rsp_data", rsp_data[g], ref_alu(t.op, t.a, t.b));
                  chk(g, "rsp_flag", rsp_flag[g], ref_cmp(t.ltgt, t.eq, t.a, t.b));
                  if (rs_ready[g][t.id]) void'(q.pop_front());
               end
            end else begin
               chk(g, "idle_alu_op",  alu_op[g],  0);
               chk(g, "idle_alu_res", alu_res[g], 0);
               chk(g, "idle_alu_reg", alu_reg[g], 0);
               chk(g, "idle_rsp0_valid", rs_valid[g][0], 0);
               chk(g, "idle_rsp1_valid", rs_valid[g][1], 0);
            end
            if (e0 || e1) begin
               t.id   = e1;
               t.op   = rq_op[g][e1];
               t.a    = rq_a[g][e1];
               t.b    = rq_b[g][e1];
               t.ltgt = rq_ltgt[g][e1];
               t.eq   = rq_eq[g][e1];
               t.acc  = cyc + 1;
               q.push_back(t);
               last_q  = e1;
               exp_gid = e1;
            end
            infl[g] = q.size() != 0;
         end
      end
   end

   task automatic push(input int idx, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [2:0] lt, input logic eq);
      stim_t s;
      s.op = op; s.a = a; s.b = b; s.ltgt = lt; s.eq = eq;
      sq[idx].push_back(s);
   endtask

   task automatic push_rand(input int idx, input int count);
      for (int k = 0; k < count; k++)
         push(idx, 4'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
              3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
   endtask

   function automatic bit all_idle();
      bit r = !infl[0] && !infl[1];
      for (int i = 0; i < 4; i++) if (sq[i].size() != 0) r = 1'b0;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++) if (rq_valid[i][j]) r = 1'b0;
      return r;
   endfunction

   task automatic drain(input string what);
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         #2;
         if (all_idle()) return;
      end
      chk(0, {what, "_drain_timeout"}, 0, 1);
   endtask

   task automatic check_cleared(input string what);
      for (int i = 0; i < 2; i++) begin
         chk(i, {what, "_rsp_data"}, rsp_data[i], 0);
         chk(i, {what, "_rsp_flag"}, rsp_flag[i], 0);
         chk(i, {what, "_grant_id"}, gid[i], 0);
         chk(i, {what, "_busy"}, busy[i], 0);
         chk(i, {what, "_alu_op"}, alu_op[i], 0);
      end
   endtask

   initial begin : p_main
      bit seen;
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin gap[i] = 0; rs_mode[i] = 0; end
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_cleared("reset");
      @(posedge clk);
      #1 rst = 1'b0;

      // single add, then wrap-around subtract and equality compare
      push(0, 4'd0, 16'h0003, 16'h0004, 3'd0, 1'b0);
      drain("single_add");
      push(0, 4'd1, 16'h0000, 16'h0001, 3'd0, 1'b0);
      push(0, 4'd1, 16'h0005, 16'h0005, 3'd0, 1'b1);
      drain("wrap_compare");

      // continuous contention
      for (int k = 0; k < 4; k++) begin
         push(0, 4'd0, 16'h0001, 16'h0001, 3'd0, 1'b0);
         push(1, 4'd1, 16'h0005, 16'h0002, 3'd0, 1'b0);
      end
      drain("contention");

      // response backpressure with the other requester waiting
      rs_mode[0] = 1;
      push(0, 4'd2, 16'h00F0, 16'h0FF0, 3'd0, 1'b0);
      seen = 1'b0;
      for (int k = 0; k < 100 && !seen; k++) begin
         @(negedge clk);
         #2;
         seen = busy[0];
      end
      chk(0, "backpressure_busy", busy[0], 1);
      push(1, 4'd3, 16'h1200, 16'h0034, 3'd0, 1'b0);
      repeat (7) @(negedge clk);
      #2 rs_mode[0] = 0;
      drain("backpressure");

      // random traffic with random backpressure
      for (int i = 0; i < 2; i++) begin gap[i] = 30; rs_mode[i] = 2; end
      push_rand(0, 40);
      push_rand(1, 40);
      drain("random");
      for (int i = 0; i < 2; i++) begin gap[i] = 0; rs_mode[i] = 0; end

      // reset while the ALU is being driven
      push(0, 4'd4, 16'h1234, 16'h1111, 3'd0, 1'b0);
      seen = 1'b0;
      for (int k = 0; k < 100 && !seen; k++) begin
         @(negedge clk);
         seen = rq_ready[0][0] && rq_valid[0][0];
      end
      chk(0, "midop_accept_seen", seen, 1);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      #2;
      check_cleared("midop_reset");
      push(0, 4'd0, 16'h0010, 16'h0020, 3'd0, 1'b0);
      push(1, 4'd0, 16'h0030, 16'h0040, 3'd0, 1'b0);
      seen = 1'b0;
      for (int k = 0; k < 100 && !seen; k++) begin
         @(negedge clk);
         seen = rq_ready[0][0] || rq_ready[0][1];
      end
      chk(0, "tie_after_reset_req0", rq_ready[0][0], 1);
      drain("after_reset");

      // HOLD_CYCLES = 3 instance
      push(2, 4'd0, 16'h0003, 16'h0004, 3'd0, 1'b0);
      drain("hold3_single");
      for (int i = 2; i < 4; i++) begin gap[i] = 20; rs_mode[i] = 2; end
      push_rand(2, 12);
      push_rand(3, 12);
      drain("hold3_random");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin : p_watchdog
      #800000;
      $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 16-bit combinational ALU between two requesters, for example the execute stage and the branch/compare unit.
- Each requester presents one operation through a valid/ready handshake.
- The block grants one requester round-robin, drives the ALU inputs from registered operands, and captures the ALU result and compare flag.
- It returns the result to the granted requester through a second valid/ready handshake.
- Only one transaction is in flight at a time.

Parameters:
- WIDTH, 16, operand/result width; must match the ALU datapath.
- OP_WIDTH, 4, ALU op code width.
- HOLD_CYCLES, 1, cycles the ALU inputs are held stable before the result is captured; minimum 1.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid / req1_valid  in  1  requester N has an operation pending.
- req0_ready / req1_ready  out  1  arbiter accepts requester N's operation this cycle.
- req0_op / req1_op  in  OP_WIDTH  ALU op code.
- req0_a / req1_a  in  WIDTH  first operand, sent to the ALU res input.
- req0_b / req1_b  in  WIDTH  second operand, sent to the ALU register input.
- req0_ltgt / req1_ltgt  in  3  compare selector.
- req0_eq / req1_eq  in  1  compare equality-class select.
- rsp0_valid / rsp1_valid  out  1  result available for requester N.
- rsp0_ready / rsp1_ready  in  1  requester N consumes the result.
- rsp_data  out  WIDTH  captured ALU result, shared by both requesters; qualified by rspN_valid.
- rsp_flag  out  1  captured ALU compare result.
- alu_op  out  OP_WIDTH  op code driven to the ALU.
- alu_res  out  WIDTH  first operand driven to the ALU.
- alu_register  out  WIDTH  second operand driven to the ALU.
- alu_ltgt  out  3  compare selector driven to the ALU.
- alu_eq  out  1  equality select driven to the ALU.
- alu_out  in  WIDTH  ALU result.
- alu_compres  in  1  ALU compare flag.
- busy  out  1  high whenever the state is not IDLE.
- grant_id  out  1  id of the current or most recent grantee.

Behaviour:
- States: IDLE, EXEC, RESP; encoded as 2-bit registers.
- Reset (synchronous, takes priority over all other logic):
  - state = IDLE; all reqN_ready and rspN_valid = 0.
  - rsp_data = 0, rsp_flag = 0; all alu_* outputs = 0.
  - hold counter = 0; busy = 0.
  - last_grant = 1, so req0 wins the first tie; grant_id = 0.
- IDLE:
  - reqN_ready is combinational. It is high only for the winner: the sole valid requester, or the requester not equal to last_grant when both are valid.
  - The transfer happens when reqN_valid and reqN_ready are both high at a rising edge. On that edge:
    - op, a, b, ltgt and eq are latched;
    - grant_id and last_grant are set to N;
    - counter = HOLD_CYCLES-1;
    - state goes to EXEC.
  - With no valid request, the block stays in IDLE and all alu_* outputs are 0.
- EXEC:
  - alu_* outputs are driven from the latched registers and stay stable for the whole state.
  - reqN_ready = 0.
  - If the counter is not 0, it decrements.
  - When the counter is 0, alu_out is captured into rsp_data and alu_compres into rsp_flag at that edge, and state goes to RESP.
- RESP:
  - rsp<grant_id>_valid = 1; the other rsp valid = 0.
  - rsp_data and rsp_flag are held stable until the handshake completes.
  - On rsp<grant_id>_valid and rsp<grant_id>_ready both high at an edge, state goes to IDLE.
  - alu_* outputs return to 0 in RESP.
- Latency with HOLD_CYCLES=1:
  - acceptance edge at cycle 0;
  - EXEC during cycle 1, capture at the end of cycle 1;
  - rsp_valid high from cycle 2.
  - Peak throughput is one operation per 3 cycles.
  - Each extra HOLD cycle adds one cycle of latency.
- Arbitration:
  - Strict alternation under continuous contention; neither requester waits more than one transaction.
  - A request that deasserts valid before it is granted is simply not served; no state is kept.
- Inputs of other requesters are ignored while busy; they must hold valid until they see ready.
- rsp_flag is sampled for every op. Requesters interpret it only for compare ops.
- The block does not decode op; it forwards it unchanged.
- Arithmetic wrap-around belongs to the ALU. The block passes all WIDTH bits through with no truncation or extension.
- Reset asserted in EXEC or RESP drops the transaction silently; no response is issued and the next grant after reset goes to req0 on a tie.

Test Plan:
- Single add: req0 op=0, a=0x0003, b=0x0004, ALU model attached -> req0_ready=1 in cycle 0; alu_res=0x0003 and alu_register=0x0004 in cycle 1; rsp0_valid=1 with rsp_data=0x0007 in cycle 2; busy cleared after rsp0_ready.
- Contention: both requesters valid continuously, req0 add 1+1 and req1 sub 5-2 -> grant order 0,1,0,1; rsp_data alternates 0x0002, 0x0003; no rsp1_valid while grant_id=0.
- Backpressure: rsp0_ready held low 5 cycles with req1 valid -> rsp_data and rsp0_valid stable for all 5 cycles, req1_ready=0 throughout; req1 granted on the first IDLE cycle after the handshake.
- Wrap and compare: sub with a=0x0000, b=0x0001 -> rsp_data=0xFFFF. Then compare with eq=1, ltgt=0, a=b=0x0005 -> rsp_flag=1.
- Reset mid-operation: assert reset during EXEC -> next edge state is IDLE, all outputs 0, no rsp valid; after release, a tie is granted to req0.
- HOLD_CYCLES=3: single request -> alu_* stable for 3 cycles; rsp_valid first high 4 cycles after the acceptance edge.
